// File: rtl/sipo_receiver.sv
// sipo_receiver: LSB-first serial-to-parallel receiver with a single-word holding register and a sticky overrun flag
module sipo_receiver #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       inb,
   input  logic                       en,
   input  logic                       clr,
   input  logic                       dout_ready,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic                       overrun,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  s_q, s_d, dout_q, dout_d, word;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovr_q, ovr_d, done;
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= EMPTY;
         s_q     <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end
   always_comb begin
      word    = {inb, s_q[WIDTH-1:1]};
      done    = en && (cnt_q == LAST);
      state_d = state_q;
      s_d     = s_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      if (clr) begin
         state_d = EMPTY;
         s_d     = '0;
         dout_d  = '0;
         cnt_d   = '0;
         ovr_d   = 1'b0;
      end else begin
         if (en) begin
            s_d   = word;
            cnt_d = done ? '0 : cnt_q + 1'b1;
         end
         // a completion while FULL either replaces the consumed word or is dropped
         case (state_q)
            EMPTY: if (done) begin
               state_d = FULL;
               dout_d  = word;
            end
            FULL: begin
               if (done && dout_ready) dout_d = word;
               else if (done) ovr_d = 1'b1;
               else if (dout_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
      end
   end
   assign dout       = dout_q;
   assign dout_valid = (state_q == FULL);
   assign overrun    = ovr_q;
   assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: directed and randomized checks of sipo_receiver against a queue-based reference model
module tb_sipo_receiver;
   localparam int W = 8;
   logic         clk = 1'b0, rst_b = 1'b1, inb = 1'b0, en = 1'b0, clr = 1'b0, dout_ready = 1'b0;
   logic [W-1:0] dout;
   logic         dout_valid, overrun;
   logic [2:0]   bit_cnt;
   int           n_vec = 0, n_err = 0;
   logic         m_bits[$];
   logic [W-1:0] m_dout = '0;
   logic         m_valid = 1'b0, m_ovr = 1'b0;

   sipo_receiver #(.WIDTH(W)) dut (
      .clk(clk), .rst_b(rst_b), .inb(inb), .en(en), .clr(clr), .dout_ready(dout_ready),
      .dout(dout), .dout_valid(dout_valid), .overrun(overrun), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_bits.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   // word-level view: collect bits in a queue, a full queue becomes a word
   task automatic model_edge();
      logic [W-1:0] w;
      logic         fin;
      w   = '0;
      fin = 1'b0;
      if (clr) begin
         model_reset();
      end else begin
         if (en) begin
            m_bits.push_back(inb);
            if (m_bits.size() == W) begin
               for (int i = 0; i < W; i++) w[i] = m_bits[i];
               m_bits.delete();
               fin = 1'b1;
            end
         end
         if (!m_valid) begin
            if (fin) begin m_dout = w; m_valid = 1'b1; end
         end else if (fin) begin
            if (dout_ready) m_dout = w;
            else m_ovr = 1'b1;
         end else if (dout_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic step(input logic e, input logic b, input logic r, input logic c);
      en = e; inb = b; dout_ready = r; clr = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic r_last);
      for (int i = 0; i < W; i++) step(1'b1, w[i], (i == W - 1) ? r_last : 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      #2 rst_b = 1'b0;
      #1;
      n_vec++;
      if ({dout, dout_valid, overrun, bit_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_async got dout=%h v=%b ovr=%b cnt=%0d exp all zero", dout, dout_valid, overrun, bit_cnt);
      end
      model_reset();
      @(negedge clk);
      rst_b = 1'b1;
      step(1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if ({dout, dout_valid, overrun, bit_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_release got dout=%h v=%b ovr=%b cnt=%0d exp all zero", dout, dout_valid, overrun, bit_cnt);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] w;
      w = 8'hA5;
      for (int i = 0; i < W; i++) begin
         n_vec++;
         if (bit_cnt !== 3'(i)) begin
            n_err++;
            $display("FAIL basic_cnt bit %0d got %0d exp %0d", i, bit_cnt, i);
         end
         step(1'b1, w[i], 1'b0, 1'b0);
      end
      n_vec++;
      if ({dout, dout_valid, bit_cnt} !== {8'hA5, 1'b1, 3'd0}) begin
         n_err++;
         $display("FAIL basic_word got dout=%h v=%b cnt=%0d exp a5 1 0", dout, dout_valid, bit_cnt);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (dout_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_consume got v=%b exp 0", dout_valid);
      end
   endtask

   task automatic test_gapped();
      logic [W-1:0] w;
      w = 8'h3C;
      for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 1'b0);
      for (int g = 0; g < 2; g++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         n_vec++;
         if (bit_cnt !== 3'd4) begin
            n_err++;
            $display("FAIL gap_cnt got %0d exp 4", bit_cnt);
         end
      end
      for (int i = 4; i < W; i++) step(1'b1, w[i], 1'b0, 1'b0);
      n_vec++;
      if ({dout, dout_valid} !== {8'h3C, 1'b1}) begin
         n_err++;
         $display("FAIL gap_word got dout=%h v=%b exp 3c 1", dout, dout_valid);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_overrun();
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      n_vec++;
      if ({dout, dout_valid, overrun} !== {8'h11, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL overrun_drop got dout=%h v=%b ovr=%b exp 11 1 1", dout, dout_valid, overrun);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({dout_valid, overrun} !== 2'b01) begin
         n_err++;
         $display("FAIL overrun_sticky got v=%b ovr=%b exp 0 1", dout_valid, overrun);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_clr got %b exp 0", overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w;
      w = 8'hC3;
      send_word(8'h5A, 1'b0);
      n_vec++;
      if ({dout, dout_valid} !== {8'h5A, 1'b1}) begin
         n_err++;
         $display("FAIL b2b_first got dout=%h v=%b exp 5a 1", dout, dout_valid);
      end
      for (int i = 0; i < W; i++) begin
         step(1'b1, w[i], (i == W - 1), 1'b0);
         n_vec++;
         if (dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_valid bit %0d got %b exp 1", i, dout_valid);
         end
      end
      n_vec++;
      if ({dout, overrun} !== {8'hC3, 1'b0}) begin
         n_err++;
         $display("FAIL b2b_second got dout=%h ovr=%b exp c3 0", dout, overrun);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_clear_reset();
      send_word(8'h77, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      n_vec++;
      if ({bit_cnt, dout_valid, overrun} !== 5'd0) begin
         n_err++;
         $display("FAIL clr_mid got cnt=%0d v=%b ovr=%b exp 0 0 0", bit_cnt, dout_valid, overrun);
      end
      send_word(8'hF0, 1'b0);
      n_vec++;
      if ({dout, dout_valid} !== {8'hF0, 1'b1}) begin
         n_err++;
         $display("FAIL clr_word got dout=%h v=%b exp f0 1", dout, dout_valid);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      #1 rst_b = 1'b0;
      #1;
      n_vec++;
      if ({bit_cnt, dout_valid, dout} !== '0) begin
         n_err++;
         $display("FAIL rst_mid got cnt=%0d v=%b dout=%h exp 0 0 00", bit_cnt, dout_valid, dout);
      end
      model_reset();
      #1 rst_b = 1'b1;
      send_word(8'hF0, 1'b0);
      n_vec++;
      if ({dout, dout_valid} !== {8'hF0, 1'b1}) begin
         n_err++;
         $display("FAIL rst_word got dout=%h v=%b exp f0 1", dout, dout_valid);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(9, 0) < 7, 1'($urandom), 1'($urandom), $urandom_range(49, 0) == 0);
         n_vec++;
         if ({dout, dout_valid, overrun, bit_cnt} !== {m_dout, m_valid, m_ovr, 3'(m_bits.size())}) begin
            n_err++;
            $display("FAIL random step %0d got dout=%h v=%b ovr=%b cnt=%0d exp dout=%h v=%b ovr=%b cnt=%0d",
                     k, dout, dout_valid, overrun, bit_cnt, m_dout, m_valid, m_ovr, m_bits.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_overrun();
      test_back_to_back();
      test_clear_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter: WIDTH, default 8, meaning parallel word width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 inb  input  1  serial data bit, LSB of each word first.
REQ-005 en  input  1  bit strobe; inb is sampled on a rising edge only when en=1.
REQ-006 clr  input  1  synchronous clear of all receiver state.
REQ-007 dout  output  WIDTH  received parallel word from the holding register.
REQ-008 dout_valid  output  1  holding register contains an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout on a rising edge when dout_valid=1 and dout_ready=1.
REQ-010 overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 bit_cnt  output  $clog2(WIDTH)  number of bits of the current partial word already received.

Function
REQ-012 Shift register S (WIDTH bits): on an edge with en=1 and clr=0, S shall load {inb, S[WIDTH-1:1]}; with en=0 it shall hold.
REQ-013 bit_cnt shall increment on every accepted bit, 0..WIDTH-1, and wrap to 0 on the bit that completes a word.
REQ-014 Word completion: an edge with en=1 and bit_cnt=WIDTH-1; completed word W = {inb, S[WIDTH-1:1]}, so the first received bit sits at dout[0].
REQ-015 Holding register FSM has two states, EMPTY (dout_valid=0) and FULL (dout_valid=1).
REQ-016 EMPTY -> FULL on completion; dout=W and dout_valid=1 are visible starting the cycle after the completing edge (latency 1).
REQ-017 FULL -> EMPTY on an edge with dout_ready=1 and no completion; dout shall hold its value, but it is don't-care while dout_valid=0.
REQ-018 FULL with completion and dout_ready=1 on the same edge: old word is consumed, W is loaded, and dout_valid stays 1 (no bubble).
REQ-019 FULL with completion and dout_ready=0: W is discarded, dout and dout_valid are unchanged, and overrun is set to 1.
REQ-020 overrun shall remain 1 until reset or clr; further drops have no additional effect.
REQ-021 dout_ready while EMPTY shall be ignored.
REQ-022 dout shall change only on a load into the holding register; it is stable while FULL and not consumed.
REQ-023 clr=1 shall clear S, bit_cnt, dout, dout_valid and overrun to 0 on the next edge, with priority over en and dout_ready; any partial word is lost.
REQ-024 A continuous stream (en=1 every cycle) with dout_ready=1 every cycle shall sustain one word per WIDTH cycles with no drops.

Reset
REQ-025 rst_b=0 shall immediately, independent of clk, force S=0, bit_cnt=0, dout=0, dout_valid=0 and overrun=0.
REQ-026 Assertion of reset mid-word shall discard the partial word; after release, the first bit with en=1 shall be bit 0 of a new word.
REQ-027 Outputs shall not change in the first cycle after rst_b deasserts unless en=1 on that edge.

Verification (WIDTH=8)
REQ-028 Basic receive: en=1 for 8 cycles, inb=1,0,1,0,0,1,0,1 -> dout=8'hA5 and dout_valid=1 one cycle after the 8th edge; bit_cnt reads 0,1..7,0.
REQ-029 Gapped strobe: send 8'h3C with en deasserted for 2 cycles between bits 3 and 4 -> dout=8'h3C; bit_cnt holds at 4 during the gap.
REQ-030 Overrun: receive 8'h11 and hold dout_ready=0, then receive 8'h22 -> dout stays 8'h11, overrun=1; then assert dout_ready for 1 cycle -> dout_valid=0, overrun stays 1.
REQ-031 Back-to-back: stream 8'h5A then 8'hC3 with dout_ready=1 at the second completion edge -> dout goes 8'h5A then 8'hC3, dout_valid stays 1 across the transition, overrun=0.
REQ-032 Clear and reset mid-word: after 5 bits, assert clr for 1 cycle -> bit_cnt=0, dout_valid=0, overrun=0; then send 8'hF0 -> dout=8'hF0. Repeat with rst_b pulsed low after 3 bits -> same result.
